// File: rtl/wshb_ram_slave.sv
// ---------------------------------------------------------------------------
// wshb_ram_slave
//
// On-chip Wishbone 16-bit slave backed by a block RAM. It stands in for the
// SDRAM controller behind wshb_intercon, so the mire writer and the vga burst
// reader can run without external memory.
//
// Features: classic cycles, linear incrementing bursts (cti=010, bte=00),
// WAIT_STATES extra cycles before the first ack of each cycle or burst,
// byte enables, and an error response for addresses beyond the memory.
//
// Ports:
//   CLK     Wishbone clock
//   RST     asynchronous active-high reset
//   cyc/stb cycle valid / strobe; a request is cyc & stb
//   we      1 = write, 0 = read
//   sel     byte enables (sel[0] -> dat[7:0], sel[1] -> dat[15:8])
//   adr     byte address; word index is adr[ADDR_W:1]
//   cti/bte cycle type identifier / burst type extension
//   dat_ms  write data (master to slave)
//   dat_sm  read data (slave to master)
//   ack     normal termination
//   err     error termination (address out of range)
//   rty     retry, never used
// ---------------------------------------------------------------------------
module wshb_ram_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  sel,
    input  logic [31:0] adr,
    input  logic [2:0]  cti,
    input  logic [1:0]  bte,
    input  logic [15:0] dat_ms,
    output logic [15:0] dat_sm,
    output logic        ack,
    output logic        err,
    output logic        rty
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("wshb_ram_slave: WAIT_STATES must lie in 0..15");
    end
    if (ADDR_W < 1 || ADDR_W > 30) begin : g_bad_addr_w
        $error("wshb_ram_slave: ADDR_W must lie in 1..30");
    end

    localparam int         DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_BURST,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [15:0]         dat_q;

    logic                req;
    logic [ADDR_W-1:0]   adr_word;
    logic                out_of_range;
    logic                burst_next;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [15:0]         rd_data;
    logic                wr_en;

    logic [15:0]         mem [DEPTH];

    assign req          = cyc & stb;
    assign adr_word     = adr[ADDR_W:1];
    assign out_of_range = (adr >> (ADDR_W + 1)) != 32'd0;
    // Only a linear incrementing burst continues past the current beat;
    // end-of-burst, classic and unsupported wrap types all finish here.
    assign burst_next   = (cti == 3'b010) && (bte == 2'b00);

    // Next-state logic. The memory is written in the beat where ack is
    // visible, and the read port is steered to the word the next acked beat
    // will present, so a burst streams without bubbles.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves a signal unassigned, which would infer a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        err_d   = 1'b0;
        rd_en   = 1'b0;
        rd_addr = ptr_q;
        wr_en   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ack_d = 1'b0;
                if (req) begin
                    ptr_d = adr_word;
                    if (out_of_range) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (WS == 4'd0) begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        rd_en   = 1'b1;
                        rd_addr = adr_word;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS;
                    end
                end
            end

            // The count hits zero on the transition into S_ACK, which puts
            // the first ack WAIT_STATES+1 cycles after req was first seen.
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        rd_en   = 1'b1;
                        rd_addr = ptr_q;
                    end
                end
            end

            S_ACK, S_BURST: begin
                if (!req) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b0;
                end else begin
                    wr_en = we;
                    if (burst_next) begin
                        state_d = S_BURST;
                        ptr_d   = ptr_q + ADDR_W'(1);
                        rd_en   = 1'b1;
                        rd_addr = ptr_q + ADDR_W'(1);
                    end else begin
                        state_d = S_IDLE;
                        ack_d   = 1'b0;
                    end
                end
            end

            S_ERR: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    // Read port with bypass: if the word being fetched is the one written on
    // this same edge, the enabled bytes come from the write data.
    always_comb begin
        rd_data = mem[rd_addr];
        if (wr_en && (rd_addr == ptr_q)) begin
            if (sel[0]) rd_data[7:0]  = dat_ms[7:0];
            if (sel[1]) rd_data[15:8] = dat_ms[15:8];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= 16'h0000;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            if (rd_en) dat_q <= rd_data;
        end
    end

    // NOTE: the storage array has no reset; clearing a RAM is neither
    // possible in block RAM nor needed, and contents survive RST. Writes
    // are still blocked during reset because the FSM is held in S_IDLE.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            if (sel[0]) mem[ptr_q][7:0]  <= dat_ms[7:0];
            if (sel[1]) mem[ptr_q][15:8] <= dat_ms[15:8];
        end
    end

    // Terminations are only visible while the master is requesting; an
    // asynchronous reset clears ack_q/err_q and so drops them at once.
    assign ack    = ack_q & req;
    assign err    = err_q & req;
    assign rty    = 1'b0;
    assign dat_sm = dat_q;

endmodule

// File: tb/tb_wshb_ram_slave.sv
// ---------------------------------------------------------------------------
// tb_wshb_ram_slave
//
// Directed bench for wshb_ram_slave. Three instances with WAIT_STATES of 2,
// 1 and 3 share every bus input except cyc, which is routed to the instance
// selected by dut_sel; the selected instance's outputs appear on m_*.
// ---------------------------------------------------------------------------
module tb_wshb_ram_slave;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cyc, stb, we;
    logic [1:0]  sel;
    logic [31:0] adr;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [15:0] dat_ms;
    int          dut_sel;

    logic        cyc_a, cyc_b, cyc_c;
    logic [15:0] dat_a, dat_b, dat_c;
    logic        ack_a, ack_b, ack_c;
    logic        err_a, err_b, err_c;
    logic        rty_a, rty_b, rty_c;

    logic        m_ack, m_err;
    logic [15:0] m_dat;

    int          total = 0;
    int          bad   = 0;

    int          bcyc [8];
    logic [15:0] bdat [8];

    int          n_t;
    logic        t_ack, t_err, post, seen;
    logic [15:0] rd;

    always #5 CLK = ~CLK;

    assign cyc_a = cyc && (dut_sel == 0);
    assign cyc_b = cyc && (dut_sel == 1);
    assign cyc_c = cyc && (dut_sel == 2);

    always_comb begin
        m_ack = 1'b0;
        m_err = 1'b0;
        m_dat = 16'h0000;
        case (dut_sel)
            0: begin m_ack = ack_a; m_err = err_a; m_dat = dat_a; end
            1: begin m_ack = ack_b; m_err = err_b; m_dat = dat_b; end
            2: begin m_ack = ack_c; m_err = err_c; m_dat = dat_c; end
            default: ;
        endcase
    end

    wshb_ram_slave #(.ADDR_W(10), .WAIT_STATES(2)) u_ws2 (
        .CLK(CLK), .RST(RST), .cyc(cyc_a), .stb(stb), .we(we), .sel(sel),
        .adr(adr), .cti(cti), .bte(bte), .dat_ms(dat_ms), .dat_sm(dat_a),
        .ack(ack_a), .err(err_a), .rty(rty_a)
    );

    wshb_ram_slave #(.ADDR_W(10), .WAIT_STATES(1)) u_ws1 (
        .CLK(CLK), .RST(RST), .cyc(cyc_b), .stb(stb), .we(we), .sel(sel),
        .adr(adr), .cti(cti), .bte(bte), .dat_ms(dat_ms), .dat_sm(dat_b),
        .ack(ack_b), .err(err_b), .rty(rty_b)
    );

    wshb_ram_slave #(.ADDR_W(10), .WAIT_STATES(3)) u_ws3 (
        .CLK(CLK), .RST(RST), .cyc(cyc_c), .stb(stb), .we(we), .sel(sel),
        .adr(adr), .cti(cti), .bte(bte), .dat_ms(dat_ms), .dat_sm(dat_c),
        .ack(ack_c), .err(err_c), .rty(rty_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Classic single transfer. Cycle 0 is the cycle req is first driven.
    // Returns the cycle of the termination, which termination was seen and
    // the read data; req is held one more cycle to confirm the termination
    // was a single pulse, then an idle cycle separates transfers.
    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [15:0] wd, input logic [1:0] s,
                        output int n_term, output logic g_ack, output logic g_err,
                        output logic [15:0] g_dat, output logic g_post);
        dut_sel = d;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_ms = wd; sel = s;
        cti = 3'b000; bte = 2'b00;
        n_term = -1; g_ack = 1'b0; g_err = 1'b0; g_dat = 16'h0000;
        for (int n = 0; n < 20 && n_term < 0; n++) begin
            @(negedge CLK);
            if (m_ack || m_err) begin
                n_term = n; g_ack = m_ack; g_err = m_err; g_dat = m_dat;
            end
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        g_post = m_ack | m_err;
        @(posedge CLK); #1;
        cyc = 1'b0; stb = 1'b0;
        @(posedge CLK); #1;
    endtask

    // Linear burst read on the WAIT_STATES=1 instance; cti switches to 111
    // once all but the last beat have been acked.
    task automatic burst_rd(input logic [31:0] a, input int beats);
        int nb = 0;
        for (int i = 0; i < 8; i++) begin
            bcyc[i] = -1;
            bdat[i] = 16'h0000;
        end
        dut_sel = 1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 2'b11;
        cti = 3'b010; bte = 2'b00;
        for (int n = 0; n < 20 && nb < beats; n++) begin
            @(negedge CLK);
            if (m_ack) begin
                bcyc[nb] = n;
                bdat[nb] = m_dat;
                nb++;
            end
            @(posedge CLK); #1;
            if (nb == beats - 1) cti = 3'b111;
        end
        cti = 3'b000;
        @(negedge CLK);
        check("burst_end_ack", {31'd0, m_ack}, 32'd0);
        @(posedge CLK); #1;
        cyc = 1'b0; stb = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        RST = 1'b1;
        dut_sel = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 2'b11;
        cti = 3'b000; bte = 2'b00; dat_ms = 16'h0000;

        // Reset held with a live request: nothing may leak out.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("rst_ack", {31'd0, m_ack}, 32'd0);
            check("rst_err", {31'd0, m_err}, 32'd0);
            check("rst_dat", {16'd0, m_dat}, 32'h0000);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        xfer(0, 1'b0, 32'h0, 16'h0, 2'b11, n_t, t_ack, t_err, rd, post);
        check("rst_release_lat", n_t, 32'd3);
        check("rst_release_ack", {31'd0, t_ack}, 32'd1);

        // Classic write and read, WAIT_STATES=2.
        xfer(0, 1'b1, 32'h10, 16'hBEEF, 2'b11, n_t, t_ack, t_err, rd, post);
        check("wr_lat", n_t, 32'd3);
        check("wr_ack", {30'd0, t_ack, t_err}, 32'b10);
        check("wr_single_pulse", {31'd0, post}, 32'd0);
        xfer(0, 1'b0, 32'h10, 16'h0, 2'b11, n_t, t_ack, t_err, rd, post);
        check("rd_lat", n_t, 32'd3);
        check("rd_data", {16'd0, rd}, 32'hBEEF);
        check("rd_single_pulse", {31'd0, post}, 32'd0);

        // Byte enables.
        xfer(0, 1'b1, 32'h10, 16'h1234, 2'b01, n_t, t_ack, t_err, rd, post);
        xfer(0, 1'b0, 32'h10, 16'h0, 2'b11, n_t, t_ack, t_err, rd, post);
        check("sel01_data", {16'd0, rd}, 32'hBE34);
        xfer(0, 1'b1, 32'h10, 16'h5600, 2'b10, n_t, t_ack, t_err, rd, post);
        xfer(0, 1'b0, 32'h10, 16'h0, 2'b11, n_t, t_ack, t_err, rd, post);
        check("sel10_data", {16'd0, rd}, 32'h5634);

        // Out-of-range write aliases word 0 but must not touch it.
        xfer(0, 1'b1, 32'h0, 16'h0F0F, 2'b11, n_t, t_ack, t_err, rd, post);
        xfer(0, 1'b1, 32'h800, 16'hAAAA, 2'b11, n_t, t_ack, t_err, rd, post);
        check("err_lat", n_t, 32'd1);
        check("err_term", {30'd0, t_ack, t_err}, 32'b01);
        check("err_single_pulse", {31'd0, post}, 32'd0);
        xfer(0, 1'b0, 32'h0, 16'h0, 2'b11, n_t, t_ack, t_err, rd, post);
        check("err_word0_kept", {16'd0, rd}, 32'h0F0F);

        // Burst read, WAIT_STATES=1.
        for (int i = 0; i < 4; i++) begin
            xfer(1, 1'b1, 32'h20 + 32'(2 * i), 16'(i), 2'b11, n_t, t_ack, t_err, rd, post);
        end
        check("ws1_wr_lat", n_t, 32'd2);
        burst_rd(32'h20, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("burst_cyc%0d", i), bcyc[i], 32'(2 + i));
            check($sformatf("burst_dat%0d", i), {16'd0, bdat[i]}, 32'(i));
        end

        // Burst wrapping from the last word to word 0.
        xfer(1, 1'b1, 32'h7FE, 16'hCAFE, 2'b11, n_t, t_ack, t_err, rd, post);
        xfer(1, 1'b1, 32'h0, 16'h1357, 2'b11, n_t, t_ack, t_err, rd, post);
        burst_rd(32'h7FE, 2);
        check("wrap_cyc0", bcyc[0], 32'd2);
        check("wrap_cyc1", bcyc[1], 32'd3);
        check("wrap_dat0", {16'd0, bdat[0]}, 32'hCAFE);
        check("wrap_dat1", {16'd0, bdat[1]}, 32'h1357);

        // Abort during wait states, WAIT_STATES=3: stb drops in cycle 2.
        xfer(2, 1'b1, 32'h10, 16'h1111, 2'b11, n_t, t_ack, t_err, rd, post);
        check("ws3_wr_lat", n_t, 32'd4);
        dut_sel = 2;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h10; dat_ms = 16'h2222;
        sel = 2'b11; cti = 3'b000; bte = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            seen = seen | m_ack | m_err;
            @(posedge CLK); #1;
        end
        stb = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        cyc = 1'b0;
        check("abort_no_ack", {31'd0, seen}, 32'd0);
        xfer(2, 1'b0, 32'h10, 16'h0, 2'b11, n_t, t_ack, t_err, rd, post);
        check("abort_rd_lat", n_t, 32'd4);
        check("abort_mem_kept", {16'd0, rd}, 32'h1111);

        // Reset in the middle of a write burst, WAIT_STATES=1.
        xfer(1, 1'b1, 32'h42, 16'h4444, 2'b11, n_t, t_ack, t_err, rd, post);
        dut_sel = 1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h40; dat_ms = 16'h7777;
        sel = 2'b11; cti = 3'b010; bte = 2'b00;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge CLK);
            seen = m_ack;
            @(posedge CLK); #1;
        end
        check("midrst_first_beat", {31'd0, seen}, 32'd1);
        #1;
        check("midrst_ack_before", {31'd0, m_ack}, 32'd1);
        RST = 1'b1;
        #1;
        check("midrst_ack_same_cycle", {31'd0, m_ack}, 32'd0);
        check("midrst_dat", {16'd0, m_dat}, 32'h0000);
        @(posedge CLK); #1;
        RST = 1'b0;
        cyc = 1'b0; stb = 1'b0; cti = 3'b000;
        @(posedge CLK); #1;
        xfer(1, 1'b0, 32'h40, 16'h0, 2'b11, n_t, t_ack, t_err, rd, post);
        check("midrst_beat0_written", {16'd0, rd}, 32'h7777);
        xfer(1, 1'b0, 32'h42, 16'h0, 2'b11, n_t, t_ack, t_err, rd, post);
        check("midrst_beat1_blocked", {16'd0, rd}, 32'h4444);

        check("rty_tied", {29'd0, rty_a, rty_b, rty_c}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
